interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
//  CPU-facing responder for the 8259A priority resolver's one-hot interrupt output.
//  Raises intr and sequences the INTA pulses (8086: 2, 8080: 3), latches the granted level into the ISR
//  and clears its IRR latch. Drives the vector/CALL bytes, and handles EOI / auto-EOI with optional rotation.
//  Drives the resolver's in_service_register, highest_level_in_service and priority_rotate inputs.
// PARAMETERS
//  OPCODE_CALL     8'hCD  first byte driven in 8080 mode
//  SPURIOUS_LEVEL  3'd7   level used when request vanishes before first INTA
// PORTS
//  clock                     in   1  system clock, all state on rising edge
//  reset_n                   in   1  synchronous, active-low reset
//  interrupt                 in   8  one-hot granted request from resolver (0 = none)
//  inta_n                    in   1  CPU acknowledge strobe, already synchronised to clock
//  mode_8086                 in   1  1 = 8086 two-pulse, 0 = 8080 three-pulse
//  vector_base               in   5  ICW2 T7..T3
//  call_address_high         in   8  8080 CALL address high byte
//  auto_eoi                  in   1  clear ISR bit at end of last INTA pulse
//  rotate_on_eoi             in   1  set priority_rotate to the level cleared by any EOI
//  eoi_command               in   1  1-cycle EOI strobe
//  eoi_specific              in   1  qualifies eoi_command: 1 = specific (eoi_level), 0 = non-specific
//  eoi_level                 in   3  level for specific EOI
//  intr                      out  1  interrupt request to CPU
//  data_out                  out  8  acknowledge byte
//  data_out_enable           out  1  data_out valid / bus drive
//  in_service_register       out  8  ISR
//  highest_level_in_service  out  8  one-hot highest-priority ISR bit under current rotation, 0 if ISR empty
//  clear_request             out  8  1-cycle one-hot pulse to clear IRR latch
//  priority_rotate           out  3  lowest-priority level; 3'b111 = IR0 highest
// BEHAVIOUR
//  - Reset (reset_n low at a clock edge, from any state, including mid-sequence):
//    state IDLE; intr=0; data_out=0; data_out_enable=0; ISR=0; clear_request=0; priority_rotate=3'b111.
//  - inta falling edge = inta_n 1 in previous cycle and 0 now; rising edge = inverse. All pulse decisions use edges.
//  - States: IDLE -> P1 -> P2 -> [P3 (8080 only)] -> IDLE. mode_8086 is sampled at the P1 entry edge.
//  - IDLE: intr <= |interrupt, registered, so intr follows interrupt with 1-cycle latency.
//    The first falling edge enters P1.
//  - P1 entry cycle:
//    * if interrupt != 0: level <= encode(interrupt); ISR[level] <= 1; clear_request = interrupt for 1 cycle.
//    * if interrupt == 0: level <= SPURIOUS_LEVEL; ISR and clear_request unchanged (spurious).
//    * intr <= 0.
//  - Data byte per pulse. Each byte is driven from the cycle after its falling edge until the cycle after the
//    following rising edge, then data_out_enable <= 0 and data_out <= 0.
//  - 8086: P1 drives nothing; P2 drives {vector_base, level}.
//  - 8080: P1 drives OPCODE_CALL; P2 drives {vector_base[4:2], level, 2'b00}; P3 drives call_address_high.
//  - Last rising edge (P2 in 8086 mode, P3 in 8080 mode): if auto_eoi, ISR[level] <= 0 (spurious: no-op).
//    Then return to IDLE.
//  - EOI is accepted in any state.
//    * specific: clears ISR[eoi_level].
//    * non-specific: clears the bit in highest_level_in_service; no-op when the ISR is empty.
//    * rotate_on_eoi: priority_rotate <= cleared level. No change when nothing is cleared.
//  - Simultaneous events: ISR_next = (ISR & ~eoi_clear & ~auto_clear) | p1_set. Set wins on the same bit.
//    If EOI and auto-EOI both rotate in one cycle, the EOI level wins.
//  - highest_level_in_service is combinational from the registered ISR and priority_rotate.
//    Priority scan starts at (priority_rotate+1) mod 8 and wraps.
// TESTING
//  - 8086 basic: vector_base=5'h08, interrupt=8'h04, two INTA pulses
//    -> intr 1 then 0 at P1; ISR=8'h04; clear_request=8'h04 for 1 cycle; P2 data_out=8'h42.
//  - 8080: vector_base=5'h10, level 5, call_address_high=8'h3A, three pulses
//    -> bytes 8'hCD, 8'h94, 8'h3A; auto_eoi=1 -> ISR=0 after last pulse.
//  - Spurious: interrupt drops to 0 before first INTA, vector_base=5'h08, 8086
//    -> data_out=8'h47; ISR stays 0; clear_request stays 0.
//  - Rotating non-specific EOI: ISR=8'h82, priority_rotate=3'b111, rotate_on_eoi=1
//    -> first EOI clears bit 1 and rotate=1; second EOI clears bit 7 and rotate=7.
//  - Simultaneous: specific EOI level 3 in the P1 entry cycle granting level 3 with ISR=8'h08 -> ISR=8'h08 (set wins).
//  - Reset mid-sequence: reset_n low during P2 drive
//    -> next cycle data_out_enable=0, intr=0, ISR=0, priority_rotate=3'b111.

Source files
------------

// File: rtl/interrupt_ack_sequencer_if.sv
// Bundle of resolver-side and CPU-side signals of the interrupt acknowledge sequencer.
// The master drives requests, acknowledge strobes and configuration; the slave answers.
interface interrupt_ack_sequencer_if;
    logic [7:0] interrupt;
    logic       inta_n;
    logic       mode_8086;
    logic [4:0] vector_base;
    logic [7:0] call_address_high;
    logic       auto_eoi;
    logic       rotate_on_eoi;
    logic       eoi_command;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       intr;
    logic [7:0] data_out;
    logic       data_out_enable;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [7:0] clear_request;
    logic [2:0] priority_rotate;

    modport master (
        output interrupt, inta_n, mode_8086, vector_base, call_address_high,
               auto_eoi, rotate_on_eoi, eoi_command, eoi_specific, eoi_level,
        input  intr, data_out, data_out_enable, in_service_register,
               highest_level_in_service, clear_request, priority_rotate
    );

    modport slave (
        input  interrupt, inta_n, mode_8086, vector_base, call_address_high,
               auto_eoi, rotate_on_eoi, eoi_command, eoi_specific, eoi_level,
        output intr, data_out, data_out_enable, in_service_register,
               highest_level_in_service, clear_request, priority_rotate
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// CPU-facing INTA sequencer: raises intr, walks the 8086/8080 acknowledge pulses, drives the
// vector/CALL bytes, and maintains the in-service register with EOI, auto-EOI and rotation.
module interrupt_ack_sequencer #(
    parameter logic [7:0] OPCODE_CALL    = 8'hCD,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                        clock,
    input  logic                        reset_n,
    interrupt_ack_sequencer_if.slave    bus
);
    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LEVELS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        P3   = 2'd3
    } state_t;

    state_t               state, state_next;
    logic                 inta_prev;
    logic                 inta_fall, inta_rise;
    logic                 mode_q, mode_next;
    logic [LEVEL_W-1:0]   level_q, level_next;
    logic                 spurious_q, spurious_next;
    logic                 intr_q, intr_next;
    logic [DATA_W-1:0]    data_q, data_next;
    logic                 oe_q, oe_next;
    logic [LEVELS-1:0]    isr_q, isr_next;
    logic [LEVELS-1:0]    clr_q, clr_next;
    logic [LEVEL_W-1:0]   rot_q, rot_next;

    logic [LEVELS-1:0]    hlis;
    logic                 hlis_found;
    logic [LEVEL_W-1:0]   scan_idx;
    logic [LEVELS-1:0]    p1_set, auto_clear, eoi_clear;
    logic                 last_rise, eoi_hit, auto_hit;
    logic [LEVEL_W-1:0]   eoi_lvl;

    // Lowest set bit of a (normally one-hot) vector.
    function automatic logic [LEVEL_W-1:0] first_set(input logic [LEVELS-1:0] v);
        logic [LEVEL_W-1:0] r;
        r = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (v[i]) r = LEVEL_W'(i);
        end
        return r;
    endfunction

    assign inta_fall = inta_prev & ~bus.inta_n;
    assign inta_rise = ~inta_prev & bus.inta_n;

    // Highest in-service level: scan starts just above the lowest-priority level and wraps.
    always_comb begin
        hlis       = '0;
        hlis_found = 1'b0;
        scan_idx   = '0;
        for (int i = 1; i <= LEVELS; i++) begin
            scan_idx = rot_q + LEVEL_W'(i);
            if (!hlis_found && isr_q[scan_idx]) begin
                hlis[scan_idx] = 1'b1;
                hlis_found     = 1'b1;
            end
        end
    end

    // Next-state, output bytes and ISR bookkeeping.
    always_comb begin
        state_next    = state;
        mode_next     = mode_q;
        level_next    = level_q;
        spurious_next = spurious_q;
        intr_next     = intr_q;
        data_next     = data_q;
        oe_next       = oe_q;
        clr_next      = '0;
        p1_set        = '0;
        auto_clear    = '0;
        last_rise     = 1'b0;
        eoi_clear     = '0;
        eoi_hit       = 1'b0;
        eoi_lvl       = '0;
        auto_hit      = 1'b0;
        rot_next      = rot_q;
        isr_next      = isr_q;

        unique case (state)
            IDLE: begin
                intr_next = |bus.interrupt;
                if (inta_fall) begin
                    state_next = P1;
                    mode_next  = bus.mode_8086;
                    intr_next  = 1'b0;
                    if (|bus.interrupt) begin
                        level_next    = first_set(bus.interrupt);
                        spurious_next = 1'b0;
                        p1_set        = LEVELS'(1) << first_set(bus.interrupt);
                        clr_next      = bus.interrupt;
                    end else begin
                        level_next    = SPURIOUS_LEVEL;
                        spurious_next = 1'b1;
                    end
                    if (!bus.mode_8086) begin
                        data_next = OPCODE_CALL;
                        oe_next   = 1'b1;
                    end
                end
            end
            P1: begin
                if (inta_rise) begin
                    data_next = '0;
                    oe_next   = 1'b0;
                end else if (inta_fall) begin
                    state_next = P2;
                    oe_next    = 1'b1;
                    data_next  = mode_q ? {bus.vector_base, level_q}
                                        : {bus.vector_base[4:2], level_q, 2'b00};
                end
            end
            P2: begin
                if (inta_rise) begin
                    data_next = '0;
                    oe_next   = 1'b0;
                    if (mode_q) begin
                        state_next = IDLE;
                        last_rise  = 1'b1;
                    end
                end else if (inta_fall && !mode_q) begin
                    state_next = P3;
                    oe_next    = 1'b1;
                    data_next  = bus.call_address_high;
                end
            end
            P3: begin
                if (inta_rise) begin
                    data_next  = '0;
                    oe_next    = 1'b0;
                    state_next = IDLE;
                    last_rise  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (last_rise && bus.auto_eoi && !spurious_q) begin
            auto_clear = LEVELS'(1) << level_q;
        end
        auto_hit = |(auto_clear & isr_q);

        if (bus.eoi_command) begin
            if (bus.eoi_specific) begin
                eoi_clear = (LEVELS'(1) << bus.eoi_level) & isr_q;
                eoi_lvl   = bus.eoi_level;
            end else begin
                eoi_clear = hlis;
                eoi_lvl   = first_set(hlis);
            end
            eoi_hit = |eoi_clear;
        end

        // An explicit EOI takes the rotation slot over a coincident auto-EOI.
        if (bus.rotate_on_eoi) begin
            if (eoi_hit)       rot_next = eoi_lvl;
            else if (auto_hit) rot_next = level_q;
        end

        isr_next = (isr_q & ~eoi_clear & ~auto_clear) | p1_set;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            inta_prev  <= 1'b1;
            mode_q     <= 1'b0;
            level_q    <= '0;
            spurious_q <= 1'b0;
            intr_q     <= 1'b0;
            data_q     <= '0;
            oe_q       <= 1'b0;
            isr_q      <= '0;
            clr_q      <= '0;
            rot_q      <= 3'b111;
        end else begin
            state      <= state_next;
            inta_prev  <= bus.inta_n;
            mode_q     <= mode_next;
            level_q    <= level_next;
            spurious_q <= spurious_next;
            intr_q     <= intr_next;
            data_q     <= data_next;
            oe_q       <= oe_next;
            isr_q      <= isr_next;
            clr_q      <= clr_next;
            rot_q      <= rot_next;
        end
    end

    assign bus.intr                     = intr_q;
    assign bus.data_out                 = data_q;
    assign bus.data_out_enable          = oe_q;
    assign bus.in_service_register      = isr_q;
    assign bus.highest_level_in_service = hlis;
    assign bus.clear_request            = clr_q;
    assign bus.priority_rotate          = rot_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed scenarios plus randomized
// acknowledge/EOI traffic checked against an array-based model of ISR and rotation.
module tb_interrupt_ack_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    interrupt_ack_sequencer_if bus();

    interrupt_ack_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    bit [7:0] m_isr;
    int       m_rot;

    logic       s_intr1;
    logic [7:0] s_clr1, s_clr2, s_data, s_isr_after;
    logic       s_oe, s_oe_after;

    function automatic int model_highest(input bit [7:0] isr, input int rot);
        for (int k = 1; k <= 8; k++) begin
            if (isr[(rot + k) % 8]) return (rot + k) % 8;
        end
        return -1;
    endfunction

    task automatic reset_dut();
        bus.interrupt = 8'h00; bus.inta_n = 1'b1; bus.mode_8086 = 1'b1;
        bus.vector_base = 5'h00; bus.call_address_high = 8'h00;
        bus.auto_eoi = 1'b0; bus.rotate_on_eoi = 1'b0; bus.eoi_command = 1'b0;
        bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        m_isr = 8'h00;
        m_rot = 7;
    endtask

    // One INTA low/high pulse, capturing outputs at fixed points.
    task automatic pulse(input bit eoi_at_fall);
        @(negedge clock);
        bus.inta_n = 1'b0;
        bus.eoi_command = eoi_at_fall;
        @(negedge clock);
        bus.eoi_command = 1'b0;
        s_intr1 = bus.intr;
        s_clr1  = bus.clear_request;
        @(negedge clock);
        s_clr2 = bus.clear_request;
        s_oe   = bus.data_out_enable;
        s_data = bus.data_out;
        @(negedge clock);
        bus.inta_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        s_oe_after  = bus.data_out_enable;
        s_isr_after = bus.in_service_register;
    endtask

    task automatic do_ack(input bit m8086, input logic [4:0] vb, input logic [7:0] irq,
                          input logic [7:0] cah, input bit aeoi, input bit eoi_p1,
                          input logic [2:0] eoi_lvl);
        int lvl, np, vbi;
        bit spur;
        logic [7:0] exp_b [3];
        bit exp_oe [3];
        spur = (irq == 8'h00);
        lvl = 7;
        for (int i = 7; i >= 0; i--) if (irq[i]) lvl = i;
        vbi = int'(vb);
        if (m8086) begin
            np = 2;
            exp_oe[0] = 1'b0; exp_b[0] = 8'h00;
            exp_oe[1] = 1'b1; exp_b[1] = 8'(vbi * 8 + lvl);
            exp_oe[2] = 1'b0; exp_b[2] = 8'h00;
        end else begin
            np = 3;
            exp_oe[0] = 1'b1; exp_b[0] = 8'hCD;
            exp_oe[1] = 1'b1; exp_b[1] = 8'((vbi / 4) * 32 + lvl * 4);
            exp_oe[2] = 1'b1; exp_b[2] = cah;
        end
        bus.interrupt = irq; bus.mode_8086 = m8086; bus.vector_base = vb;
        bus.call_address_high = cah; bus.auto_eoi = aeoi;
        bus.eoi_specific = 1'b1; bus.eoi_level = eoi_lvl;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.intr !== (irq != 8'h00)) begin
            failures++;
            $display("FAIL intr_raise: got %b expected %b", bus.intr, irq != 8'h00);
        end
        for (int p = 0; p < np; p++) begin
            pulse(p == 0 && eoi_p1);
            if (p == 0) begin
                if (eoi_p1 && m_isr[eoi_lvl]) begin
                    m_isr[eoi_lvl] = 1'b0;
                    if (bus.rotate_on_eoi) m_rot = int'(eoi_lvl);
                end
                if (!spur) m_isr[lvl] = 1'b1;
                bus.interrupt = 8'h00;
                checks++;
                if (s_intr1 !== 1'b0) begin
                    failures++;
                    $display("FAIL intr_drop: got %b expected 0", s_intr1);
                end
                checks++;
                if (s_clr1 !== irq) begin
                    failures++;
                    $display("FAIL clear_request: got %h expected %h", s_clr1, irq);
                end
                checks++;
                if (s_clr2 !== 8'h00) begin
                    failures++;
                    $display("FAIL clear_request_width: got %h expected 00", s_clr2);
                end
            end
            checks++;
            if (s_oe !== exp_oe[p] || s_data !== exp_b[p]) begin
                failures++;
                $display("FAIL byte%0d: got oe=%b data=%h expected oe=%b data=%h",
                         p + 1, s_oe, s_data, exp_oe[p], exp_b[p]);
            end
            checks++;
            if (s_oe_after !== 1'b0) begin
                failures++;
                $display("FAIL release%0d: got oe=%b expected 0", p + 1, s_oe_after);
            end
            if (p == np - 1) begin
                if (aeoi && !spur && m_isr[lvl]) begin
                    m_isr[lvl] = 1'b0;
                    if (bus.rotate_on_eoi) m_rot = lvl;
                end
                checks++;
                if (s_isr_after !== m_isr) begin
                    failures++;
                    $display("FAIL isr_after_ack: got %h expected %h", s_isr_after, m_isr);
                end
            end
        end
        checks++;
        if (bus.priority_rotate !== 3'(m_rot)) begin
            failures++;
            $display("FAIL rotate_after_ack: got %0d expected %0d", bus.priority_rotate, m_rot);
        end
    endtask

    task automatic do_eoi(input bit spec, input logic [2:0] lvl);
        int h, tgt;
        logic [7:0] exp_h;
        h = model_highest(m_isr, m_rot);
        exp_h = (h < 0) ? 8'h00 : 8'(1 << h);
        checks++;
        if (bus.highest_level_in_service !== exp_h) begin
            failures++;
            $display("FAIL highest_level: got %h expected %h", bus.highest_level_in_service, exp_h);
        end
        bus.eoi_command = 1'b1; bus.eoi_specific = spec; bus.eoi_level = lvl;
        @(negedge clock);
        bus.eoi_command = 1'b0;
        tgt = spec ? int'(lvl) : h;
        if (tgt >= 0 && m_isr[tgt]) begin
            m_isr[tgt] = 1'b0;
            if (bus.rotate_on_eoi) m_rot = tgt;
        end
        checks++;
        if (bus.in_service_register !== m_isr || bus.priority_rotate !== 3'(m_rot)) begin
            failures++;
            $display("FAIL eoi: got isr=%h rot=%0d expected isr=%h rot=%0d",
                     bus.in_service_register, bus.priority_rotate, m_isr, m_rot);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (bus.intr !== 1'b0 || bus.data_out !== 8'h00 || bus.data_out_enable !== 1'b0 ||
            bus.in_service_register !== 8'h00 || bus.clear_request !== 8'h00 ||
            bus.priority_rotate !== 3'b111 || bus.highest_level_in_service !== 8'h00) begin
            failures++;
            $display("FAIL reset: got intr=%b d=%h oe=%b isr=%h clr=%h rot=%0d",
                     bus.intr, bus.data_out, bus.data_out_enable, bus.in_service_register,
                     bus.clear_request, bus.priority_rotate);
        end
    endtask

    task automatic test_8086_basic();
        do_ack(1'b1, 5'h08, 8'h04, 8'h00, 1'b0, 1'b0, 3'd0);
        do_eoi(1'b1, 3'd2);
    endtask

    task automatic test_8080_auto_eoi();
        do_ack(1'b0, 5'h10, 8'h20, 8'h3A, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic test_spurious();
        bus.interrupt = 8'h08;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.intr !== 1'b1) begin
            failures++;
            $display("FAIL intr_follow_high: got %b expected 1", bus.intr);
        end
        bus.interrupt = 8'h00;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.intr !== 1'b0) begin
            failures++;
            $display("FAIL intr_follow_low: got %b expected 0", bus.intr);
        end
        do_ack(1'b1, 5'h08, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0);
        do_ack(1'b0, 5'h08, 8'h00, 8'h55, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic test_rotating_eoi();
        bus.rotate_on_eoi = 1'b1;
        do_ack(1'b1, 5'h01, 8'h02, 8'h00, 1'b0, 1'b0, 3'd0);
        do_ack(1'b1, 5'h01, 8'h80, 8'h00, 1'b0, 1'b0, 3'd0);
        do_eoi(1'b0, 3'd0);
        do_eoi(1'b0, 3'd0);
        do_eoi(1'b0, 3'd0);
        bus.rotate_on_eoi = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_ack(1'b1, 5'h08, 8'h08, 8'h00, 1'b0, 1'b0, 3'd0);
        do_ack(1'b1, 5'h08, 8'h08, 8'h00, 1'b0, 1'b1, 3'd3);
        do_eoi(1'b1, 3'd3);
    endtask

    task automatic test_reset_mid();
        bus.rotate_on_eoi = 1'b1;
        do_ack(1'b1, 5'h08, 8'h10, 8'h00, 1'b0, 1'b0, 3'd0);
        do_eoi(1'b0, 3'd0);
        bus.interrupt = 8'h40; bus.mode_8086 = 1'b1; bus.vector_base = 5'h08;
        repeat (2) @(negedge clock);
        pulse(1'b0);
        @(negedge clock);
        bus.inta_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.data_out_enable !== 1'b1 || bus.data_out !== 8'h46) begin
            failures++;
            $display("FAIL mid_drive: got oe=%b d=%h expected oe=1 d=46",
                     bus.data_out_enable, bus.data_out);
        end
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.data_out_enable !== 1'b0 || bus.data_out !== 8'h00 || bus.intr !== 1'b0 ||
            bus.in_service_register !== 8'h00 || bus.priority_rotate !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset: got oe=%b d=%h intr=%b isr=%h rot=%0d",
                     bus.data_out_enable, bus.data_out, bus.intr,
                     bus.in_service_register, bus.priority_rotate);
        end
        reset_n = 1'b1;
        bus.inta_n = 1'b1; bus.interrupt = 8'h00; bus.rotate_on_eoi = 1'b0;
        m_isr = 8'h00; m_rot = 7;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] irq;
            bus.rotate_on_eoi = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 8));
            irq = (r == 8) ? 8'h00 : 8'(1 << r);
            do_ack(1'($urandom_range(0, 1)), 5'($urandom), irq, 8'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 3'($urandom));
            for (int e = 0; e < int'($urandom_range(0, 2)); e++) begin
                do_eoi(1'($urandom_range(0, 1)), 3'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_8086_basic();
        test_8080_auto_eoi();
        test_spurious();
        test_rotating_eoi();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
